// File: rtl/sys_arr_mac_sequencer.sv
// Sequencer that feeds one systolic-array MAC: per job it loads a weight, then for each
// (value, psum) pair it starts the MAC, waits for value_ready and hands the result downstream.
package sys_arr_pkg;
  localparam int unsigned DW = 16;
endpackage

module sys_arr_mac_sequencer #(
  parameter int unsigned DW      = sys_arr_pkg::DW,
  parameter int unsigned CW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_weight,
  input  logic [CW-1:0] cfg_count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_value,
  input  logic [DW-1:0] in_psum,
  output logic          mac_start,
  output logic [DW-1:0] mac_weight,
  output logic [DW-1:0] mac_in_value,
  output logic [DW-1:0] mac_in_accumulate,
  input  logic [DW-1:0] mac_out_accumulate,
  input  logic          mac_value_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          timeout_err
);

  localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCW-1:0] TMO_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  remain;
  logic [WCW-1:0] wait_cnt;

  logic cfg_fire;
  logic in_fire;
  logic resp;
  logic tmo;
  logic out_fire;
  logic last;

  assign cfg_ready = (state == S_IDLE);
  assign in_ready  = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cfg_fire   = 1'b0;
    in_fire    = 1'b0;
    resp       = 1'b0;
    tmo        = 1'b0;
    out_fire   = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          cfg_fire = 1'b1;
          if (cfg_count != '0) state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (in_valid) begin
          in_fire    = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A ready seen while the start pulse is still out belongs to no request of ours.
        if (!mac_start && mac_value_ready) begin
          resp       = 1'b1;
          state_next = S_OUT;
        end else if (wait_cnt == TMO_LAST) begin
          tmo        = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_fire = 1'b1;
          if (remain == CW'(1)) begin
            last       = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_ISSUE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mac_start         <= 1'b0;
      mac_weight        <= '0;
      mac_in_value      <= '0;
      mac_in_accumulate <= '0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
      remain            <= '0;
      wait_cnt          <= '0;
    end else begin
      done      <= (cfg_fire && (cfg_count == '0)) || (out_fire && last);
      mac_start <= in_fire;
      if (cfg_fire) begin
        mac_weight  <= cfg_weight;
        remain      <= cfg_count;
        timeout_err <= 1'b0;
      end
      if (in_fire) begin
        mac_in_value      <= in_value;
        mac_in_accumulate <= in_psum;
        wait_cnt          <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
      if (tmo) timeout_err <= 1'b1;
      if (resp) begin
        out_data  <= mac_out_accumulate;
        out_valid <= 1'b1;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        remain    <= remain - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sys_arr_mac_sequencer.sv
// Directed bench for sys_arr_mac_sequencer; the MAC side is driven by hand with known responses.
module tb_sys_arr_mac_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned TIMEOUT = 64;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_weight;
  logic [CW-1:0] cfg_count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_value;
  logic [DW-1:0] in_psum;
  logic          mac_start;
  logic [DW-1:0] mac_weight;
  logic [DW-1:0] mac_in_value;
  logic [DW-1:0] mac_in_accumulate;
  logic [DW-1:0] mac_out_accumulate;
  logic          mac_value_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          timeout_err;

  sys_arr_mac_sequencer #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_weight(cfg_weight), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_psum(in_psum),
    .mac_start(mac_start), .mac_weight(mac_weight), .mac_in_value(mac_in_value),
    .mac_in_accumulate(mac_in_accumulate), .mac_out_accumulate(mac_out_accumulate),
    .mac_value_ready(mac_value_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int res_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;

  always @(posedge CLK) begin
    if (mac_start) start_cnt++;
    if (out_valid && out_ready) res_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, mac_start, 0);
    check({tag, "_weight"}, mac_weight, 0);
    check({tag, "_in_value"}, mac_in_value, 0);
    check({tag, "_in_acc"}, mac_in_accumulate, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  task automatic cfg(input logic [DW-1:0] w, input logic [CW-1:0] c);
    cfg_valid = 1'b1; cfg_weight = w; cfg_count = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic issue(input logic [DW-1:0] v, input logic [DW-1:0] p);
    in_valid = 1'b1; in_value = v; in_psum = p;
    tick();
    in_valid = 1'b0;
  endtask

  // lat = extra WAIT cycles with ready low after the start cycle; stall = cycles out_ready held low
  task automatic do_pair(input logic [DW-1:0] v, input logic [DW-1:0] p, input logic [DW-1:0] r,
                         input int lat, input int stall);
    issue(v, p);
    check("start", mac_start, 1);
    check("in_value", mac_in_value, {16'h0, v});
    check("in_acc", mac_in_accumulate, {16'h0, p});
    check("in_ready_low", in_ready, 0);
    tick();
    check("start_one_cycle", mac_start, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("no_early_valid", out_valid, 0);
    end
    mac_value_ready = 1'b1; mac_out_accumulate = r;
    tick();
    mac_value_ready = 1'b0; mac_out_accumulate = '0;
    check("out_valid", out_valid, 1);
    check("out_data", out_data, {16'h0, r});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, {16'h0, r});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, d0, b0;
    logic [DW-1:0] v, p;
    nRST = 1'b0; cfg_valid = 1'b0; cfg_weight = '0; cfg_count = '0;
    in_valid = 1'b0; in_value = '0; in_psum = '0;
    mac_out_accumulate = '0; mac_value_ready = 1'b0; out_ready = 1'b0;
    #12;
    check_reset("por");
    tick();
    nRST = 1'b1;
    tick();

    // single pair: weight 3, (5,10), MAC answers 25 two cycles after start
    cfg(16'd3, 8'd1);
    check("s_busy", busy, 1);
    check("s_cfg_ready", cfg_ready, 0);
    check("s_in_ready", in_ready, 1);
    check("s_weight", mac_weight, 3);
    do_pair(16'd5, 16'd10, 16'd25, 1, 0);
    check("s_done", done, 1);
    check("s_cfg_ready_back", cfg_ready, 1);
    check("s_busy_low", busy, 0);
    check("s_out_valid_low", out_valid, 0);
    tick();
    check("s_done_pulse", done, 0);
    check("s_weight_kept", mac_weight, 3);

    // four back-to-back pairs, pair 2 back-pressured for 3 cycles
    s0 = start_cnt; r0 = res_cnt;
    cfg(16'd7, 8'd4);
    for (int i = 0; i < 4; i++) begin
      v = DW'(i + 1);
      p = DW'(16 * i);
      do_pair(v, p, DW'(7 * (i + 1) + 16 * i), 0, (i == 1) ? 3 : 0);
      check("b_weight", mac_weight, 7);
      if (i < 3) begin
        check("b_no_done", done, 0);
        check("b_in_ready", in_ready, 1);
      end else begin
        check("b_done", done, 1);
      end
    end
    check("b_starts", start_cnt - s0, 4);
    check("b_results", res_cnt - r0, 4);

    // zero-count job
    tick();
    s0 = start_cnt; b0 = busy_cyc;
    cfg(16'h55, 8'd0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_cfg_ready", cfg_ready, 1);
    check("z_weight", mac_weight, 16'h55);
    tick();
    check("z_done_pulse", done, 0);
    check("z_no_start", start_cnt - s0, 0);
    check("z_busy_never", busy_cyc - b0, 0);

    // timeout: MAC never answers
    d0 = done_cnt; r0 = res_cnt;
    cfg(16'd9, 8'd2);
    issue(16'd1, 16'd2);
    repeat (TIMEOUT - 1) tick();
    check("t_not_yet", timeout_err, 0);
    check("t_still_busy", busy, 1);
    tick();
    check("t_flag", timeout_err, 1);
    check("t_idle", busy, 0);
    check("t_cfg_ready", cfg_ready, 1);
    check("t_no_valid", out_valid, 0);
    check("t_no_done", done, 0);
    tick(); tick();
    check("t_sticky", timeout_err, 1);
    check("t_done_cnt", done_cnt - d0, 0);
    check("t_res_cnt", res_cnt - r0, 0);
    cfg(16'd9, 8'd0);
    check("t_cleared", timeout_err, 0);
    check("t_clear_done", done, 1);
    tick();

    // spurious value_ready in IDLE, ISSUE and the start cycle
    mac_value_ready = 1'b1; mac_out_accumulate = 16'hDEAD;
    tick();
    check("sp_idle", out_valid, 0);
    cfg(16'd2, 8'd1);
    check("sp_cfg", out_valid, 0);
    tick();
    check("sp_issue", out_valid, 0);
    check("sp_issue_ready", in_ready, 1);
    issue(16'd4, 16'd1);
    mac_out_accumulate = 16'hBEEF;
    tick();
    check("sp_start_cycle", out_valid, 0);
    mac_value_ready = 1'b0;
    tick();
    check("sp_wait", out_valid, 0);
    mac_value_ready = 1'b1; mac_out_accumulate = 16'h1234;
    tick();
    mac_value_ready = 1'b0; mac_out_accumulate = '0;
    check("sp_valid", out_valid, 1);
    check("sp_data", out_data, 16'h1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sp_done", done, 1);
    tick();

    // asynchronous reset mid-WAIT, then a normal job
    cfg(16'd5, 8'd1);
    issue(16'd6, 16'd7);
    tick();
    check("r_in_wait", busy, 1);
    #2 nRST = 1'b0;
    #1;
    check_reset("mid");
    tick();
    nRST = 1'b1;
    tick();
    cfg(16'd3, 8'd1);
    check("r_weight", mac_weight, 3);
    do_pair(16'd5, 16'd10, 16'd25, 1, 0);
    check("r_done", done, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
